// File: rtl/usb_bulk_out_ctrl_if.sv
// usb_bulk_out_ctrl_if: receiver, FIFO and handshake-transmitter signals of the bulk OUT sequencer.
interface usb_bulk_out_ctrl_if;
    logic       rx_en;
    logic       rx_tok_vld;
    logic       rx_pid_vld;
    logic [3:0] rx_pid;
    logic [6:0] rx_addr;
    logic [3:0] rx_endp;
    logic       rx_byte_vld;
    logic       rx_eop;
    logic       crc_status;
    logic       fifo_full;
    logic       fifo_commit;
    logic       fifo_rollback;
    logic       pckt_rcvd;
    logic       tx_start;
    logic [3:0] tx_pid;
    logic       tx_done;
    logic       data_toggle;
    logic [7:0] nak_cnt;

    modport slave (
        output rx_en, fifo_commit, fifo_rollback, pckt_rcvd, tx_start, tx_pid, data_toggle, nak_cnt,
        input  rx_tok_vld, rx_pid_vld, rx_pid, rx_addr, rx_endp, rx_byte_vld, rx_eop,
               crc_status, fifo_full, tx_done
    );

    modport master (
        input  rx_en, fifo_commit, fifo_rollback, pckt_rcvd, tx_start, tx_pid, data_toggle, nak_cnt,
        output rx_tok_vld, rx_pid_vld, rx_pid, rx_addr, rx_endp, rx_byte_vld, rx_eop,
               crc_status, fifo_full, tx_done
    );
endinterface

// File: rtl/usb_bulk_out_ctrl.sv
// usb_bulk_out_ctrl: bulk OUT transaction sequencer (token qualify, DATA0/1 toggle, ACK/NAK/silence).
// Define USB_RX_TIMEOUT_EN to add a token-to-data timeout of TIMEOUT_CYC cycles.
module usb_bulk_out_ctrl #(
    parameter logic [6:0] DEV_ADDR = 7'h55,
    parameter logic [3:0] DEV_ENDP = 4'h0,
    parameter int         MAX_PKT  = 64
`ifdef USB_RX_TIMEOUT_EN
    , parameter int       TIMEOUT_CYC = 144
`endif
) (
    input logic                sysclk,
    input logic                rst,
    usb_bulk_out_ctrl_if.slave bus
);
    localparam logic [3:0] PID_OUT = 4'b0001;
    localparam logic [3:0] PID_ACK = 4'b0010;
    localparam logic [3:0] PID_NAK = 4'b1010;
    localparam logic [7:0] MAX_B   = 8'(MAX_PKT);

    typedef enum logic [2:0] {IDLE, WAIT_DATA, RCV_DATA, DECIDE, SEND_HS, WAIT_TX} state_t;

    state_t     state, state_n;
    logic       rcv_tog, rcv_tog_n;
    logic [7:0] byte_cnt, cnt_n, inc;
    logic       full_f, full_n, ovf_f, ovf_n, crc_f, crc_n;
    logic       commit_n, rollback_n, rcvd_n, start_n, tog_n, rx_en_n;
    logic [3:0] pid_n;
    logic [7:0] nak_n;
    logic       tok_match, is_data, timeout;

    assign inc       = byte_cnt + 8'd1;
    assign tok_match = bus.rx_tok_vld && bus.rx_pid == PID_OUT && bus.rx_addr == DEV_ADDR && bus.rx_endp == DEV_ENDP;
    assign is_data   = bus.rx_pid[2:0] == 3'b011;

`ifdef USB_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;
    // Held at the load value outside WAIT_DATA, so it restarts on every entry.
    always_ff @(posedge sysclk or posedge rst)
        if (rst)
            to_cnt <= TW'(TIMEOUT_CYC);
        else if (state != WAIT_DATA)
            to_cnt <= TW'(TIMEOUT_CYC);
        else if (to_cnt != '0)
            to_cnt <= to_cnt - TW'(1);
    assign timeout = to_cnt == '0;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        rcv_tog_n  = rcv_tog;
        cnt_n      = byte_cnt;
        full_n     = full_f;
        ovf_n      = ovf_f;
        crc_n      = crc_f;
        commit_n   = 1'b0;
        rollback_n = 1'b0;
        rcvd_n     = 1'b0;
        start_n    = 1'b0;
        pid_n      = bus.tx_pid;
        tog_n      = bus.data_toggle;
        nak_n      = bus.nak_cnt;
        case (state)
            IDLE: state_n = tok_match ? WAIT_DATA : IDLE;
            WAIT_DATA:
                if (bus.rx_pid_vld && is_data) begin
                    rcv_tog_n = bus.rx_pid[3];
                    cnt_n     = 8'd0;
                    full_n    = 1'b0;
                    ovf_n     = 1'b0;
                    state_n   = RCV_DATA;
                end else if (bus.rx_pid_vld || bus.rx_tok_vld || timeout)
                    state_n = IDLE;
            RCV_DATA: begin
                cnt_n   = bus.rx_byte_vld ? inc : byte_cnt;
                ovf_n   = ovf_f || (bus.rx_byte_vld && inc > MAX_B);
                full_n  = full_f || bus.fifo_full;
                crc_n   = bus.rx_eop ? bus.crc_status : crc_f;
                state_n = bus.rx_eop ? DECIDE : RCV_DATA;
            end
            DECIDE:
                if (!crc_f || ovf_f) begin
                    rollback_n = 1'b1;
                    state_n    = IDLE;
                end else if (full_f) begin
                    rollback_n = 1'b1;
                    pid_n      = PID_NAK;
                    nak_n      = bus.nak_cnt + {7'd0, bus.nak_cnt != 8'hFF};
                    state_n    = SEND_HS;
                end else if (rcv_tog == bus.data_toggle) begin
                    commit_n = 1'b1;
                    rcvd_n   = 1'b1;
                    tog_n    = !bus.data_toggle;
                    pid_n    = PID_ACK;
                    state_n  = SEND_HS;
                end else begin
                    rollback_n = 1'b1;
                    pid_n      = PID_ACK;
                    state_n    = SEND_HS;
                end
            SEND_HS: begin
                start_n = 1'b1;
                state_n = WAIT_TX;
            end
            // tx_done coinciding with the tx_start pulse is too early to be real.
            WAIT_TX: state_n = (bus.tx_done && !bus.tx_start) ? IDLE : WAIT_TX;
            default: state_n = IDLE;
        endcase
        rx_en_n = state_n != SEND_HS && state_n != WAIT_TX;
    end

    always_ff @(posedge sysclk or posedge rst)
        if (rst) begin
            state             <= IDLE;
            rcv_tog           <= 1'b0;
            byte_cnt          <= 8'd0;
            full_f            <= 1'b0;
            ovf_f             <= 1'b0;
            crc_f             <= 1'b0;
            bus.rx_en         <= 1'b1;
            bus.fifo_commit   <= 1'b0;
            bus.fifo_rollback <= 1'b0;
            bus.pckt_rcvd     <= 1'b0;
            bus.tx_start      <= 1'b0;
            bus.tx_pid        <= 4'b0000;
            bus.data_toggle   <= 1'b0;
            bus.nak_cnt       <= 8'd0;
        end else begin
            state             <= state_n;
            rcv_tog           <= rcv_tog_n;
            byte_cnt          <= cnt_n;
            full_f            <= full_n;
            ovf_f             <= ovf_n;
            crc_f             <= crc_n;
            bus.rx_en         <= rx_en_n;
            bus.fifo_commit   <= commit_n;
            bus.fifo_rollback <= rollback_n;
            bus.pckt_rcvd     <= rcvd_n;
            bus.tx_start      <= start_n;
            bus.tx_pid        <= pid_n;
            bus.data_toggle   <= tog_n;
            bus.nak_cnt       <= nak_n;
        end
endmodule

// File: tb/tb_usb_bulk_out_ctrl.sv
// tb_usb_bulk_out_ctrl: randomized transaction bench with a packet-level outcome model.
module tb_usb_bulk_out_ctrl;
    localparam logic [6:0] DEV_ADDR    = 7'h55;
    localparam logic [3:0] DEV_ENDP    = 4'h0;
    localparam int         MAX_PKT     = 64;
    localparam int         TIMEOUT_CYC = 144;
    localparam logic [3:0] OUT = 4'b0001, ACK = 4'b0010, NAK = 4'b1010, IN = 4'b1001;

    logic sysclk = 1'b0;
    logic rst = 1'b1;
    usb_bulk_out_ctrl_if bus();
    usb_bulk_out_ctrl dut (.sysclk(sysclk), .rst(rst), .bus(bus.slave));

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int failures = 0;
    logic       exp_tog = 1'b0;
    logic [7:0] exp_nak = 8'd0;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic clr_in();
        bus.rx_tok_vld  = 0;
        bus.rx_pid_vld  = 0;
        bus.rx_pid      = 0;
        bus.rx_addr     = 0;
        bus.rx_endp     = 0;
        bus.rx_byte_vld = 0;
        bus.rx_eop      = 0;
        bus.crc_status  = 0;
        bus.fifo_full   = 0;
        bus.tx_done     = 0;
    endtask

    task automatic token(input logic [3:0] pid, input logic [6:0] a, input logic [3:0] e);
        bus.rx_tok_vld = 1;
        bus.rx_pid     = pid;
        bus.rx_addr    = a;
        bus.rx_endp    = e;
        tick();
        clr_in();
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if ({bus.rx_en, bus.tx_start, bus.tx_pid, bus.fifo_commit, bus.fifo_rollback, bus.pckt_rcvd,
             bus.data_toggle, bus.nak_cnt} !== {1'b1, 1'b0, 4'b0000, 3'b000, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL %s outputs got en=%b st=%b pid=%b c=%b r=%b p=%b tog=%b nak=%0d exp reset values",
                     tag, bus.rx_en, bus.tx_start, bus.tx_pid, bus.fifo_commit, bus.fifo_rollback,
                     bus.pckt_rcvd, bus.data_toggle, bus.nak_cnt);
        end
    endtask

    // One full OUT transaction; expected outcome derived from the packet-level rules.
    task automatic run_pkt(input logic tog, input int n, input logic crc, input bit full,
                           input bit early, input int gap, input string tag);
        logic [7:0] cv, rv, pv, sv, ev, cv_e, rv_e, sv_e, ev_e;
        logic [3:0] pid3, pid4, epid;
        bit ign, hs, com;
        int slots;
        ign = 0;
`ifdef USB_RX_TIMEOUT_EN
        ign = gap >= TIMEOUT_CYC + 4;
`endif
        com = 0;
        hs = 0;
        epid = ACK;
        if (!ign && crc && n <= MAX_PKT) begin
            hs = 1;
            if (full) begin
                epid = NAK;
                if (exp_nak != 8'd255) exp_nak++;
            end else if (tog == exp_tog) begin
                com = 1;
                exp_tog = !exp_tog;
            end
        end
        cv_e = com ? 8'h02 : 8'h00;
        rv_e = (!ign && !com) ? 8'h02 : 8'h00;
        sv_e = hs ? 8'h04 : 8'h00;
        ev_e = hs ? 8'hF1 : 8'hFF;
        cv = 0; rv = 0; pv = 0; sv = 0; ev = 0; pid3 = 0; pid4 = 0;
        token(OUT, DEV_ADDR, DEV_ENDP);
        repeat (gap) tick();
        bus.rx_pid_vld = 1;
        bus.rx_pid = {tog, 3'b011};
        tick();
        clr_in();
        slots = n > 0 ? n : 1;
        for (int i = 0; i < slots; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            bus.rx_byte_vld = n > 0;
            bus.fifo_full   = full && i == slots / 2;
            bus.rx_eop      = i == slots - 1;
            bus.crc_status  = (i == slots - 1) ? crc : 1'($urandom);
            tick();
            clr_in();
        end
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) begin
                tick();
                bus.tx_done = 0;
            end
            cv[k-1] = bus.fifo_commit;
            rv[k-1] = bus.fifo_rollback;
            pv[k-1] = bus.pckt_rcvd;
            sv[k-1] = bus.tx_start;
            ev[k-1] = bus.rx_en;
            if (k == 3) pid3 = bus.tx_pid;
            if (k == 4) pid4 = bus.tx_pid;
            bus.tx_done = (k == 3 && early) || k == 4;
        end
        bus.tx_done = 0;
        checks++;
        if (cv !== cv_e) begin failures++; $display("FAIL %s fifo_commit trace got=%b exp=%b", tag, cv, cv_e); end
        checks++;
        if (rv !== rv_e) begin failures++; $display("FAIL %s fifo_rollback trace got=%b exp=%b", tag, rv, rv_e); end
        checks++;
        if (pv !== cv_e) begin failures++; $display("FAIL %s pckt_rcvd trace got=%b exp=%b", tag, pv, cv_e); end
        checks++;
        if (sv !== sv_e) begin failures++; $display("FAIL %s tx_start trace got=%b exp=%b", tag, sv, sv_e); end
        checks++;
        if (ev !== ev_e) begin failures++; $display("FAIL %s rx_en trace got=%b exp=%b", tag, ev, ev_e); end
        if (hs) begin
            checks++;
            if (pid3 !== epid || pid4 !== epid) begin
                failures++;
                $display("FAIL %s tx_pid got=%b/%b exp=%b", tag, pid3, pid4, epid);
            end
        end
        checks++;
        if (bus.data_toggle !== exp_tog) begin failures++; $display("FAIL %s data_toggle got=%b exp=%b", tag, bus.data_toggle, exp_tog); end
        checks++;
        if (bus.nak_cnt !== exp_nak) begin failures++; $display("FAIL %s nak_cnt got=%0d exp=%0d", tag, bus.nak_cnt, exp_nak); end
    endtask

    // A data packet that the block must ignore entirely (it is sitting in IDLE).
    task automatic orphan(input string tag);
        logic seen, en;
        seen = 0;
        en = 1;
        bus.rx_pid_vld = 1;
        bus.rx_pid = 4'b1011;
        tick();
        clr_in();
        for (int i = 0; i < 9; i++) begin
            bus.rx_byte_vld = i < 3;
            bus.rx_eop = i == 2;
            bus.crc_status = 1;
            tick();
            clr_in();
            seen |= bus.fifo_commit | bus.fifo_rollback | bus.pckt_rcvd | bus.tx_start;
            en &= bus.rx_en;
        end
        checks++;
        if (seen !== 1'b0 || en !== 1'b1 || bus.data_toggle !== exp_tog) begin
            failures++;
            $display("FAIL %s ignored packet got strobe=%b rx_en=%b tog=%b exp 0/1/%b",
                     tag, seen, en, bus.data_toggle, exp_tog);
        end
    endtask

    task automatic test_reset();
        clr_in();
        rst = 1;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 0;
        tick();
        check_reset_vals("reset_release");
    endtask

    task automatic test_basic();
        run_pkt(1'b0, 10, 1'b1, 0, 0, 0, "data0_ack");
        run_pkt(1'b0, 10, 1'b1, 0, 0, 0, "retransmit");
    endtask

    task automatic test_addr_mismatch();
        token(OUT, 7'h12, DEV_ENDP);
        orphan("bad_addr");
        token(OUT, DEV_ADDR, 4'h3);
        orphan("bad_endp");
        token(IN, DEV_ADDR, DEV_ENDP);
        orphan("in_token");
        token(OUT, DEV_ADDR, DEV_ENDP);
        bus.rx_pid_vld = 1;
        bus.rx_pid = ACK;
        tick();
        clr_in();
        orphan("wait_non_data");
        run_pkt(1'b1, 5, 1'b0, 0, 0, 0, "crc_bad");
    endtask

    task automatic test_nak();
        run_pkt(exp_tog, 4, 1'b1, 1, 0, 0, "nak_first");
        for (int i = 0; i < 256; i++)
            run_pkt(1'($urandom), 2, 1'b1, 1, 0, 0, "nak_sat");
        checks++;
        if (bus.nak_cnt !== 8'd255) begin failures++; $display("FAIL nak_saturate got=%0d exp=255", bus.nak_cnt); end
    endtask

    task automatic test_overflow();
        run_pkt(exp_tog, 65, 1'b1, 0, 0, 0, "overflow_65");
        run_pkt(exp_tog, 64, 1'b1, 0, 0, 0, "max_64");
        run_pkt(exp_tog, 0, 1'b1, 0, 0, 0, "zero_len");
    endtask

    task automatic test_early_done();
        run_pkt(exp_tog, 3, 1'b1, 0, 1, 0, "early_tx_done");
    endtask

    task automatic test_timeout();
        run_pkt(exp_tog, 6, 1'b1, 0, 0, 150, "long_gap");
        run_pkt(exp_tog, 6, 1'b1, 0, 0, 20, "short_gap");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++)
            run_pkt(($urandom_range(0, 3) == 0) ? !exp_tog : exp_tog, int'($urandom_range(0, 70)),
                    $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
                    1'($urandom), int'($urandom_range(0, 3)), "random");
    endtask

    task automatic test_reset_mid();
        if (exp_tog == 1'b0) run_pkt(1'b0, 3, 1'b1, 0, 0, 0, "pre_reset");
        token(OUT, DEV_ADDR, DEV_ENDP);
        bus.rx_pid_vld = 1;
        bus.rx_pid = 4'b1011;
        tick();
        clr_in();
        repeat (3) begin
            bus.rx_byte_vld = 1;
            tick();
            clr_in();
        end
        #2 rst = 1;
        #1 check_reset_vals("reset_mid_packet");
        exp_tog = 0;
        exp_nak = 0;
        tick();
        rst = 0;
        tick();
        run_pkt(1'b0, 8, 1'b1, 0, 0, 0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_addr_mismatch();
        test_nak();
        test_overflow();
        test_early_done();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
